lsu_mem_stage: RTL and testbench
================================

LSU_MEM_STAGE -- requirements
Module: lsu_mem_stage

Interface
REQ-001 Parameter TIMEOUT_CYC, default 255, SHALL set the bus-wait cycles (REQ+WAIT) before an access is aborted.
REQ-002 clk  input  1  single clock; all state SHALL update on posedge clk.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 alu_data_m  input  32  effective address from EX/MEM.
REQ-005 st_data_m  input  32  store data, unaligned (rs2 value).
REQ-006 mem_rd_m  input  1  load in MEM.
REQ-007 mem_wr_m  input  1  store in MEM.
REQ-008 funct3_m  input  3  access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu.
REQ-009 dmem_req  output  1  bus request; held until dmem_gnt.
REQ-010 dmem_we  output  1  1 = write.
REQ-011 dmem_addr  output  32  word address, bits [1:0] forced 0.
REQ-012 dmem_be  output  4  byte enables.
REQ-013 dmem_wdata  output  32  lane-shifted store data.
REQ-014 dmem_gnt  input  1  request accepted this cycle.
REQ-015 dmem_rvalid  input  1  read data valid this cycle.
REQ-016 dmem_rdata  input  32  read word.
REQ-017 ld_data_m  output  32  extended load result, registered, to MEM/WB.
REQ-018 lsu_stall  output  1  pipeline freeze (drives MEM/WB en low and upstream hold).
REQ-019 misalign_err  output  1  one-cycle pulse, misaligned access.
REQ-020 bus_err  output  1  one-cycle pulse, timeout.

Function
REQ-021 FSM states IDLE, REQ, WAIT, DONE SHALL be implemented.
REQ-022 IDLE: (mem_rd_m|mem_wr_m) and aligned -> REQ, capturing address, be, wdata, we, funct3; else stay.
REQ-023 Misaligned (w: addr[1:0]!=0; h/hu: addr[0]!=0): no bus request, misalign_err pulse next cycle, ld_data_m<=0, lsu_stall 0, stay IDLE.
REQ-024 mem_rd_m and mem_wr_m both high SHALL be treated as store.
REQ-025 REQ: dmem_req=1; on dmem_gnt: store -> DONE, load -> WAIT.
REQ-026 WAIT: on dmem_rvalid, ld_data_m <= extended lane of dmem_rdata, -> DONE; rvalid in other states ignored.
REQ-027 DONE: unconditionally -> IDLE; SHALL NOT start a new access (same instruction still present).
REQ-028 lsu_stall SHALL be combinational: 1 in REQ and WAIT, and in IDLE when an aligned access is presented; 0 in DONE.
REQ-029 Byte lane = addr[1:0]; sb: be=0001<<lane, wdata = byte replicated x4; sh: be=0011<<lane, halfword replicated x2; sw: be=1111.
REQ-030 Loads: lb/lh sign-extend, lbu/hu zero-extend selected lane; lw passes word; invalid funct3 SHALL behave as lw.
REQ-031 Stores SHALL leave ld_data_m unchanged.
REQ-032 Min latency (gnt and rvalid first cycle): store 2 stall cycles, load 3 stall cycles; stall-low DONE cycle follows.
REQ-033 Timeout counter resets on REQ entry, increments in REQ/WAIT; at TIMEOUT_CYC -> DONE, bus_err pulse, load ld_data_m<=0; saturates, no wrap.
REQ-034 Inputs alu_data_m..funct3_m SHALL be sampled only at IDLE->REQ; later changes ignored.

Reset
REQ-035 rst_n low SHALL immediately force IDLE, counter 0, ld_data_m 0, dmem_req/dmem_we/dmem_be/misalign_err/bus_err 0, dmem_addr/dmem_wdata 0.
REQ-036 Reset mid-REQ/WAIT SHALL drop dmem_req in the same cycle; a late dmem_rvalid after release SHALL be ignored.

Verification
REQ-037 lw addr 0x100, gnt cycle1, rvalid cycle2 rdata 0xDEADBEEF -> stall 1,1,1,0; ld_data_m=0xDEADBEEF; dmem_addr 0x100, be 1111.
REQ-038 sb addr 0x203 data 0x000000A5 -> dmem_addr 0x200, be 1000, wdata 0xA5A5A5A5, we 1; ld_data_m unchanged.
REQ-039 lb addr 0x1 rdata 0x00008000 -> ld_data_m 0xFFFFFF80; same with lbu -> 0x00000080.
REQ-040 lw addr 0x102 -> misalign_err pulse, dmem_req never 1, stall 0, ld_data_m 0.
REQ-041 lw with rvalid never asserted, TIMEOUT_CYC=4 -> bus_err pulse after 4 wait cycles, ld_data_m 0, FSM returns IDLE.
REQ-042 rst_n low while in WAIT, then rvalid -> dmem_req 0 at once, ld_data_m stays 0, state IDLE.

Source files
------------

// File: rtl/lsu_mem_stage_if.sv
// Data-memory bus between the load/store unit (master) and memory (slave).
// The request is held until granted; read data returns later with rvalid.
interface lsu_mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/lsu_mem_stage.sv
// MEM-stage load/store unit: aligns store data onto byte lanes, runs one
// bus access per instruction (IDLE -> REQ -> [WAIT] -> DONE), extends load
// data, stalls the pipeline while the bus is busy and aborts stuck accesses.
module lsu_mem_stage #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [31:0]            alu_data_m,
  input  logic [31:0]            st_data_m,
  input  logic                   mem_rd_m,
  input  logic                   mem_wr_m,
  input  logic [2:0]             funct3_m,
  lsu_mem_stage_if.master        dmem,
  output logic [31:0]            ld_data_m,
  output logic                   lsu_stall,
  output logic                   misalign_err,
  output logic                   bus_err
);
  localparam int CW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYC);
  // Abort happens in the cycle whose counter value is TIMEOUT_CYC-1, so the
  // access gets exactly TIMEOUT_CYC bus-wait cycles.
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYC > 0) ? CW'(TIMEOUT_CYC - 1) : '0;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_sat;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   ld_data_q, ld_data_d;
  logic [3:0]    be_q, be_d;
  logic          we_q, we_d;
  logic [2:0]    funct3_q, funct3_d;
  logic [1:0]    lane_q, lane_d;
  logic          misalign_q, misalign_d;
  logic          bus_err_q, bus_err_d;

  logic          access, is_byte, is_half, aligned, timed_out;
  logic [1:0]    lane;
  logic [3:0]    be_new;
  logic [31:0]   wdata_new, rd_shift, ld_ext;

  // Size decode: unknown funct3 encodings are handled as full words.
  assign access    = mem_rd_m | mem_wr_m;
  assign lane      = alu_data_m[1:0];
  assign is_byte   = (funct3_m[1:0] == 2'b00);
  assign is_half   = (funct3_m[1:0] == 2'b01);
  assign aligned   = is_byte | (is_half ? ~lane[0] : (lane == 2'b00));
  assign timed_out = (cnt_q >= CNT_LAST);
  assign cnt_sat   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

  // Place store data on its byte lanes by replication and build byte enables
  always_comb begin
    be_new    = 4'b1111;
    wdata_new = st_data_m;
    if (is_byte) begin
      be_new    = 4'b0001 << lane;
      wdata_new = {4{st_data_m[7:0]}};
    end else if (is_half) begin
      be_new    = 4'b0011 << lane;
      wdata_new = {2{st_data_m[15:0]}};
    end
  end

  assign rd_shift = dmem.dmem_rdata >> {lane_q, 3'b000};

  // Select the addressed lane of the returned word and sign/zero extend it
  always_comb begin
    case (funct3_q)
      3'b000:  ld_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b100:  ld_ext = {24'h0, rd_shift[7:0]};
      3'b001:  ld_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b101:  ld_ext = {16'h0, rd_shift[15:0]};
      default: ld_ext = dmem.dmem_rdata;
    endcase
  end

  // Access FSM: next state, request capture, load result, stall and error pulses
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    funct3_d   = funct3_q;
    lane_d     = lane_q;
    ld_data_d  = ld_data_q;
    misalign_d = 1'b0;
    bus_err_d  = 1'b0;
    lsu_stall  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (access && aligned) begin
          lsu_stall = 1'b1;
          state_d   = S_REQ;
          cnt_d     = '0;
          addr_d    = {alu_data_m[31:2], 2'b00};
          be_d      = be_new;
          wdata_d   = wdata_new;
          we_d      = mem_wr_m;   // rd+wr together is a store
          funct3_d  = funct3_m;
          lane_d    = lane;
        end else if (access) begin
          misalign_d = 1'b1;
          ld_data_d  = '0;
        end
      end
      S_REQ: begin
        lsu_stall = 1'b1;
        cnt_d     = cnt_sat;
        if (dmem.dmem_gnt) begin
          state_d = we_q ? S_DONE : S_WAIT;
        end else if (timed_out) begin
          state_d   = S_DONE;
          bus_err_d = 1'b1;
          if (!we_q) ld_data_d = '0;
        end
      end
      S_WAIT: begin
        lsu_stall = 1'b1;
        cnt_d     = cnt_sat;
        if (dmem.dmem_rvalid) begin
          ld_data_d = ld_ext;
          state_d   = S_DONE;
        end else if (timed_out) begin
          state_d   = S_DONE;
          bus_err_d = 1'b1;
          ld_data_d = '0;
        end
      end
      // The finished instruction is still in MEM this cycle; never restart.
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      funct3_q   <= '0;
      lane_q     <= '0;
      ld_data_q  <= '0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      funct3_q   <= funct3_d;
      lane_q     <= lane_d;
      ld_data_q  <= ld_data_d;
      misalign_q <= misalign_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign dmem.dmem_req   = (state_q == S_REQ);
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_be    = be_q;
  assign dmem.dmem_wdata = wdata_q;
  assign ld_data_m       = ld_data_q;
  assign misalign_err    = misalign_q;
  assign bus_err         = bus_err_q;
endmodule

// File: tb/tb_lsu_mem_stage.sv
// Bench for lsu_mem_stage: directed corner cases plus randomized accesses,
// checked every cycle against a transaction-level model of the LSU.
`timescale 1ns/1ps
module tb_lsu_mem_stage;
  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] alu_data_m = '0;
  logic [31:0] st_data_m = '0;
  logic        mem_rd_m = 1'b0;
  logic        mem_wr_m = 1'b0;
  logic [2:0]  funct3_m = '0;
  logic [31:0] ld_data_m;
  logic        lsu_stall, misalign_err, bus_err;

  lsu_mem_stage_if dmem_bus();

  lsu_mem_stage #(.TIMEOUT_CYC(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_data_m(alu_data_m), .st_data_m(st_data_m),
    .mem_rd_m(mem_rd_m), .mem_wr_m(mem_wr_m), .funct3_m(funct3_m),
    .dmem(dmem_bus),
    .ld_data_m(ld_data_m), .lsu_stall(lsu_stall),
    .misalign_err(misalign_err), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  logic        exp_stall, exp_req, exp_mis, exp_berr, exp_we;
  logic [31:0] exp_ld, exp_addr, exp_wdata;
  logic [3:0]  exp_be;
  logic [31:0] ld_model = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, expv, $time);
    end
  endtask

  // Per-cycle comparison of DUT outputs against the model expectations
  always @(negedge clk) begin
    if (chk_en) begin
      check("lsu_stall", 32'(lsu_stall), 32'(exp_stall));
      check("dmem_req", 32'(dmem_bus.dmem_req), 32'(exp_req));
      check("misalign_err", 32'(misalign_err), 32'(exp_mis));
      check("bus_err", 32'(bus_err), 32'(exp_berr));
      check("ld_data_m", ld_data_m, exp_ld);
      if (exp_req) begin
        check("dmem_addr", dmem_bus.dmem_addr, exp_addr);
        check("dmem_be", 32'(dmem_bus.dmem_be), 32'(exp_be));
        check("dmem_we", 32'(dmem_bus.dmem_we), 32'(exp_we));
        check("dmem_wdata", dmem_bus.dmem_wdata, exp_wdata);
      end
    end
  end

  // ---------------- model ----------------
  function automatic int size_of(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      default:    return 4;
    endcase
  endfunction

  function automatic logic [31:0] load_value(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] w);
    logic [31:0] v;
    int sh;
    sh = 8 * int'(a[1:0]);
    case (f3)
      3'd0: begin v = (w >> sh) & 32'hFF;   if (v >= 32'd128)   v = v - 32'd256;   end
      3'd4: v = (w >> sh) & 32'hFF;
      3'd1: begin v = (w >> sh) & 32'hFFFF; if (v >= 32'd32768) v = v - 32'h10000; end
      3'd5: v = (w >> sh) & 32'hFFFF;
      default: v = w;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [31:0] a);
    int sz;
    sz = size_of(f3);
    if (sz == 1) return 4'(1 << a[1:0]);
    if (sz == 2) return 4'(3 << a[1:0]);
    return 4'hF;
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
    int sz;
    sz = size_of(f3);
    if (sz == 1) return (d & 32'hFF) * 32'h01010101;
    if (sz == 2) return (d & 32'hFFFF) * 32'h00010001;
    return d;
  endfunction

  task automatic set_idle_exp();
    exp_stall = 1'b0; exp_req = 1'b0; exp_mis = 1'b0; exp_berr = 1'b0;
    exp_ld = ld_model; exp_addr = '0; exp_be = '0; exp_we = 1'b0; exp_wdata = '0;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    mem_rd_m = 1'b0; mem_wr_m = 1'b0;
    alu_data_m = $urandom; st_data_m = $urandom; funct3_m = 3'($urandom);
    dmem_bus.dmem_gnt = 1'($urandom); dmem_bus.dmem_rvalid = 1'($urandom);
    dmem_bus.dmem_rdata = $urandom;
    set_idle_exp();
    @(negedge clk);
  endtask

  // One instruction held in MEM; g = grant delay, r = rvalid delay after grant.
  task automatic run_txn(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rdw,
                         input int g, input int r,
                         output int n_stall, output int n_req, output int n_mis, output int n_berr,
                         output logic [31:0] q_addr, output logic [3:0] q_be,
                         output logic [31:0] q_wdata, output logic q_we);
    int sz, nb, nreq_cyc, abort_idx, k;
    bit mis, ok, in_req, valid_pt;
    logic [31:0] new_ld;
    sz = size_of(f3);
    mis = (sz == 2 && a[0]) || (sz == 4 && a[1:0] != 2'b00);
    n_stall = 0; n_req = 0; n_mis = 0; n_berr = 0;
    q_addr = '0; q_be = '0; q_wdata = '0; q_we = 1'b0;
    if (mis) begin
      for (int c = 0; c < 2; c++) begin
        @(posedge clk); #1;
        mem_rd_m = (c == 0) ? rd : 1'b0; mem_wr_m = (c == 0) ? wr : 1'b0;
        funct3_m = f3; alu_data_m = a; st_data_m = sd;
        dmem_bus.dmem_gnt = 1'($urandom); dmem_bus.dmem_rvalid = 1'($urandom);
        dmem_bus.dmem_rdata = $urandom;
        if (c == 1) ld_model = '0;
        set_idle_exp();
        exp_mis = (c == 1);
        @(negedge clk);
        n_stall += int'(lsu_stall); n_req += int'(dmem_bus.dmem_req);
        n_mis += int'(misalign_err); n_berr += int'(bus_err);
      end
      return;
    end
    if (g > T - 1) begin
      ok = 1'b0; nreq_cyc = T; nb = T;
    end else if (wr) begin
      ok = 1'b1; nreq_cyc = g + 1; nb = g + 1;
    end else begin
      nreq_cyc = g + 1;
      abort_idx = (T - 1 > g + 1) ? T - 1 : g + 1;
      if (g + 1 + r <= abort_idx) begin ok = 1'b1; nb = g + 2 + r; end
      else begin ok = 1'b0; nb = abort_idx + 1; end
    end
    new_ld = wr ? ld_model : (ok ? load_value(f3, a, rdw) : 32'h0);
    for (int c = 0; c <= nb + 1; c++) begin
      @(posedge clk); #1;
      k = c - 1;
      mem_rd_m = rd; mem_wr_m = wr;
      if (c == 0 || c == nb + 1) begin
        funct3_m = f3; alu_data_m = a; st_data_m = sd;
      end else begin
        funct3_m = 3'($urandom); alu_data_m = $urandom; st_data_m = $urandom;
      end
      in_req   = (c >= 1 && c <= nb && k < nreq_cyc);
      valid_pt = (!wr && ok && c >= 1 && c <= nb && k == g + 1 + r);
      dmem_bus.dmem_gnt    = in_req ? (k == g) : 1'($urandom);
      dmem_bus.dmem_rvalid = valid_pt ? 1'b1 :
                             ((c >= 1 && c <= nb && !in_req) ? 1'b0 : 1'($urandom));
      dmem_bus.dmem_rdata  = valid_pt ? rdw : $urandom;
      if (c == nb + 1) ld_model = new_ld;
      exp_stall = (c <= nb); exp_req = in_req; exp_mis = 1'b0;
      exp_berr = (c == nb + 1) && !ok; exp_ld = ld_model;
      exp_addr = a & ~32'h3; exp_be = store_be(f3, a);
      exp_wdata = store_data(f3, sd); exp_we = wr;
      @(negedge clk);
      n_stall += int'(lsu_stall); n_req += int'(dmem_bus.dmem_req);
      n_mis += int'(misalign_err); n_berr += int'(bus_err);
      if (dmem_bus.dmem_req === 1'b1 && n_req == 1) begin
        q_addr = dmem_bus.dmem_addr; q_be = dmem_bus.dmem_be;
        q_wdata = dmem_bus.dmem_wdata; q_we = dmem_bus.dmem_we;
      end
    end
  endtask

  // Reset asserted while in REQ (in_wait=0) or WAIT (in_wait=1), then a stray rvalid.
  task automatic reset_mid(input bit in_wait);
    chk_en = 1'b0;
    @(posedge clk); #1;
    mem_rd_m = 1'b1; mem_wr_m = 1'b0; funct3_m = 3'b010; alu_data_m = 32'h40;
    dmem_bus.dmem_gnt = 1'b0; dmem_bus.dmem_rvalid = 1'b0;
    @(posedge clk); #1;
    check("rst_pre_req", 32'(dmem_bus.dmem_req), 32'd1);
    dmem_bus.dmem_gnt = in_wait;
    if (in_wait) begin
      @(posedge clk); #1;
      dmem_bus.dmem_gnt = 1'b0;
      check("rst_pre_wait_stall", 32'(lsu_stall), 32'd1);
    end
    #1 mem_rd_m = 1'b0; rst_n = 1'b0;
    #1;
    check("rst_req_drop", 32'(dmem_bus.dmem_req), 32'd0);
    check("rst_ld_clear", ld_data_m, 32'd0);
    check("rst_stall", 32'(lsu_stall), 32'd0);
    check("rst_be_clear", 32'(dmem_bus.dmem_be), 32'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    dmem_bus.dmem_rvalid = 1'b1; dmem_bus.dmem_rdata = 32'h12345678;
    @(posedge clk); #1;
    dmem_bus.dmem_rvalid = 1'b0;
    check("rst_late_rvalid_ld", ld_data_m, 32'd0);
    check("rst_late_rvalid_req", 32'(dmem_bus.dmem_req), 32'd0);
    check("rst_late_rvalid_stall", 32'(lsu_stall), 32'd0);
    ld_model = '0;
    set_idle_exp();
    chk_en = 1'b1;
  endtask

  initial begin
    int ns, nr, nm, nbe, kind;
    logic [31:0] qa, qw, a;
    logic [3:0] qb;
    logic qwe, rd, wr;
    logic [2:0] f3;
    logic [2:0] f3tab [5];
    f3tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    dmem_bus.dmem_gnt = 1'b0; dmem_bus.dmem_rvalid = 1'b0; dmem_bus.dmem_rdata = '0;
    set_idle_exp();
    #1 rst_n = 1'b0;
    #11;
    check("reset_req", 32'(dmem_bus.dmem_req), 32'd0);
    check("reset_we", 32'(dmem_bus.dmem_we), 32'd0);
    check("reset_be", 32'(dmem_bus.dmem_be), 32'd0);
    check("reset_addr", dmem_bus.dmem_addr, 32'd0);
    check("reset_wdata", dmem_bus.dmem_wdata, 32'd0);
    check("reset_ld", ld_data_m, 32'd0);
    check("reset_errs", {30'd0, misalign_err, bus_err}, 32'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    chk_en = 1'b1;
    idle_cycle();

    // lw 0x100: minimum latency load
    run_txn(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, ns, nr, nm, nbe, qa, qb, qw, qwe);
    #1;
    check("lw_ld", ld_data_m, 32'hDEADBEEF);
    check("lw_stall_cycles", 32'(ns), 32'd3);
    check("lw_addr", qa, 32'h100);
    check("lw_be", 32'(qb), 32'hF);
    idle_cycle();
    // sb 0x203
    run_txn(1'b0, 1'b1, 3'b000, 32'h203, 32'hA5, 32'h0, 0, 0, ns, nr, nm, nbe, qa, qb, qw, qwe);
    #1;
    check("sb_addr", qa, 32'h200);
    check("sb_be", 32'(qb), 32'h8);
    check("sb_wdata", qw, 32'hA5A5A5A5);
    check("sb_we", 32'(qwe), 32'd1);
    check("sb_ld_kept", ld_data_m, 32'hDEADBEEF);
    check("sb_stall_cycles", 32'(ns), 32'd2);
    idle_cycle();
    // lb / lbu at 0x1
    run_txn(1'b1, 1'b0, 3'b000, 32'h1, 32'h0, 32'h00008000, 1, 1, ns, nr, nm, nbe, qa, qb, qw, qwe);
    #1 check("lb_sign", ld_data_m, 32'hFFFFFF80);
    idle_cycle();
    run_txn(1'b1, 1'b0, 3'b100, 32'h1, 32'h0, 32'h00008000, 0, 2, ns, nr, nm, nbe, qa, qb, qw, qwe);
    #1 check("lbu_zero", ld_data_m, 32'h00000080);
    idle_cycle();
    // misaligned lw 0x102
    run_txn(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 0, 0, ns, nr, nm, nbe, qa, qb, qw, qwe);
    #1;
    check("mis_pulse", 32'(nm), 32'd1);
    check("mis_no_req", 32'(nr), 32'd0);
    check("mis_no_stall", 32'(ns), 32'd0);
    check("mis_ld", ld_data_m, 32'd0);
    idle_cycle();
    // load timeout: no rvalid
    run_txn(1'b1, 1'b0, 3'b010, 32'h104, 32'h0, 32'h0, 0, 50, ns, nr, nm, nbe, qa, qb, qw, qwe);
    #1;
    check("to_berr_pulse", 32'(nbe), 32'd1);
    check("to_stall_cycles", 32'(ns), 32'd5);
    check("to_ld", ld_data_m, 32'd0);
    idle_cycle();
    // store never granted
    run_txn(1'b0, 1'b1, 3'b010, 32'h108, 32'h55, 32'h0, 9, 0, ns, nr, nm, nbe, qa, qb, qw, qwe);
    #1 check("st_to_berr", 32'(nbe), 32'd1);
    idle_cycle();
    reset_mid(1'b0);
    reset_mid(1'b1);
    idle_cycle();

    for (int i = 0; i < 300; i++) begin
      kind = int'($urandom_range(0, 4));
      rd = (kind == 0 || kind == 2 || kind == 4);
      wr = (kind == 1 || kind == 2);
      f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom) : f3tab[$urandom_range(0, 4)];
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[0] = 1'b0;
      if ($urandom_range(0, 3) != 0 && size_of(f3) == 4) a[1] = 1'b0;
      if (kind == 3) begin
        idle_cycle();
      end else begin
        run_txn(rd, wr, f3, a, $urandom, $urandom,
                ($urandom_range(0, 7) == 0) ? int'($urandom_range(3, 6)) : int'($urandom_range(0, 2)),
                ($urandom_range(0, 7) == 0) ? int'($urandom_range(2, 5)) : int'($urandom_range(0, 1)),
                ns, nr, nm, nbe, qa, qb, qw, qwe);
      end
      if ($urandom_range(0, 1) == 0) idle_cycle();
    end
    idle_cycle();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
